// File: rtl/imm_encoder.sv
// Immediate encoder: expands a 32-bit constant into an addiu/ori/lui sequence, or
// encodes a branch target into a beq word. One request in, one or two words out.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// EMIT1 | first (or only) instruction word presented on out_instr
// EMIT2 | trailing ori word of a two-word li
// ERR   | one-cycle err pulse for an unencodable beq target
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [31:0] req_value,
  input  logic [31:0] req_pc,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        err
);

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMIT1 = 2'd1,
    S_EMIT2 = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_word2;
  logic        r_two;
  logic        r_req_ready;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic        r_out_last;
  logic        r_err;

  state_t      w_state_nxt;
  logic [31:0] w_word2_nxt;
  logic        w_two_nxt;
  logic        w_req_ready_nxt;
  logic        w_out_valid_nxt;
  logic [31:0] w_out_instr_nxt;
  logic        w_out_last_nxt;
  logic        w_err_nxt;

  logic [15:0] w_hi;
  logic [15:0] w_lo;
  logic        w_sext_fit;
  logic [31:0] w_li_first;
  logic [31:0] w_li_second;
  logic        w_li_two;
  logic [31:0] w_diff;
  logic        w_beq_ok;
  logic [31:0] w_beq_word;
  logic        w_unused_diff_lsb;
  logic        w_accept;

  // li selection: shortest sequence, first match wins
  always_comb begin
    w_hi        = req_value[31:16];
    w_lo        = req_value[15:0];
    w_sext_fit  = (req_value[31:15] == 17'h00000) || (req_value[31:15] == 17'h1FFFF);
    w_li_second = {OP_ORI, req_rt, req_rt, w_lo};
    w_li_two    = 1'b0;
    if (w_sext_fit) begin
      w_li_first = {OP_ADDIU, 5'd0, req_rt, w_lo};
    end else if (w_hi == 16'h0000) begin
      w_li_first = {OP_ORI, 5'd0, req_rt, w_lo};
    end else if (w_lo == 16'h0000) begin
      w_li_first = {OP_LUI, 5'd0, req_rt, w_hi};
    end else begin
      w_li_first = {OP_LUI, 5'd0, req_rt, w_hi};
      w_li_two   = 1'b1;
    end
  end

  // Word offset must fit a signed 16-bit field: diff[31:17] is the sign extension of diff[17]
  assign w_diff            = req_value - req_pc - 32'd4;
  assign w_beq_ok          = (req_value[1:0] == 2'b00) && (w_diff[31:17] == {15{w_diff[17]}});
  assign w_beq_word        = {OP_BEQ, req_rs, req_rt, w_diff[17:2]};
  assign w_unused_diff_lsb = ^w_diff[1:0];

  assign w_accept = req_valid & r_req_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_word2_nxt     = r_word2;
    w_two_nxt       = r_two;
    w_req_ready_nxt = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_out_instr_nxt = r_out_instr;
    w_out_last_nxt  = r_out_last;
    w_err_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (req_mode) begin
            w_two_nxt   = 1'b0;
            w_word2_nxt = 32'd0;
            if (w_beq_ok) begin
              w_state_nxt     = S_EMIT1;
              w_out_valid_nxt = 1'b1;
              w_out_instr_nxt = w_beq_word;
              w_out_last_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_ERR;
              w_err_nxt   = 1'b1;
            end
          end else begin
            w_state_nxt     = S_EMIT1;
            w_two_nxt       = w_li_two;
            w_word2_nxt     = w_li_second;
            w_out_valid_nxt = 1'b1;
            w_out_instr_nxt = w_li_first;
            w_out_last_nxt  = ~w_li_two;
          end
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end

      S_EMIT1: begin
        w_out_valid_nxt = 1'b1;
        if (out_ready) begin
          if (r_two) begin
            w_state_nxt     = S_EMIT2;
            w_out_instr_nxt = r_word2;
            w_out_last_nxt  = 1'b1;
          end else begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
            w_req_ready_nxt = 1'b1;
          end
        end
      end

      S_EMIT2: begin
        w_out_valid_nxt = 1'b1;
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end

      S_ERR: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_word2     <= 32'd0;
      r_two       <= 1'b0;
      r_req_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word2     <= w_word2_nxt;
      r_two       <= w_two_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_last  <= w_out_last_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_last  = r_out_last;
  assign err       = r_err;

endmodule
